mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Execute-stage multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline.
//  Operands are the E-stage rs/rt values after the forwarding muxes.
//  A multi-cycle busy counter models MULT/DIV latency.
//  busy feeds the D-stage stall logic, which must hold mult/div/mfhi/mflo/mthi/mtlo in D while busy|start.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy after a multiply start (>=1)
//  DIV_CYCLES   10  cycles busy after a divide start (>=1)
// PORTS
//  clk     in   1   pipeline clock, rising edge
//  reset   in   1   asynchronous, active-high; clears all state
//  start   in   1   one-cycle pulse: E-stage instr is a mult/div-class op
//  op      in   4   operation, encoding from mdu_pkg
//  rs_val  in   32  forwarded rs operand
//  rt_val  in   32  forwarded rt operand
//  busy    out  1   operation in flight; HI/LO not yet committed
//  hi      out  32  HI register
//  lo      out  32  LO register
// BEHAVIOUR
//  - Reset, asynchronous: busy=0, hi=0, lo=0, count=0, pending=0. Reset mid-operation discards the pending result.
//  - FSM has two states, IDLE and BUSY. IDLE->BUSY on start with a mult/div op.
//  - On that start edge, count loads MULT_CYCLES or DIV_CYCLES and the result is computed into pend_hi/pend_lo.
//  - In BUSY, count decrements every cycle. When count==1, the next edge commits pend_hi/pend_lo to hi/lo and returns to IDLE.
//  - busy is high for exactly N cycles after the start edge. The new hi/lo is visible the cycle busy falls.
//  - MULT: signed 32x32->64. MULTU: unsigned. hi=prod[63:32], lo=prod[31:0].
//  - DIV: signed, truncates toward zero. lo=quotient; hi=remainder, sign of dividend. DIVU: unsigned.
//  - Divide by zero: still busy for DIV_CYCLES; hi/lo keep their previous values.
//  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
//  - MTHI/MTLO: single cycle, never asserts busy. hi (or lo) <= rs_val on the start edge.
//  - start while busy is ignored entirely: no restart, no mthi/mtlo write. The stall logic prevents this case.
//  - Undefined op codes with start: no effect.
//  - All arithmetic is in 64-bit intermediates. Signed ops sign-extend the operands, unsigned ops zero-extend.
// CONFIGURATION
//  MDU_MADD_EN defined: adds MADD, MADDU, MSUB, MSUBU (SPECIAL2, opcode 011100).
//   Each has MULT latency. {hi,lo} <= {hi,lo} +/- product, wrapping mod 2^64.
//   The accumulate reads the {hi,lo} value held at commit time.
//  MDU_MADD_EN undefined: those op codes are treated as undefined (no effect), and the accumulator logic is absent.
// STRUCTURE
//  - mdu_pkg: 4-bit op codes (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU).
//  - mdu_pkg also holds the state encoding (MDU_IDLE, MDU_BUSY) and the default latency constants.
//  - Sub-module mdu_arith: purely combinational; takes op, rs_val, rt_val and returns the 64-bit result plus a div_by_zero flag.
//  - The top level holds the FSM, counter, pending and HI/LO registers.
// TESTING
//  1. MULT rs=3, rt=0xFFFFFFFE -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  2. DIVU rs=7, rt=2 -> busy high 10 cycles; then lo=3, hi=1.
//     DIV rs=0xFFFFFFF9, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  3. hi=0x11, lo=0x22, then DIV rt=0 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
//  4. MULT start, then a second start (MULTU) at cycle 2 -> ignored.
//     Commit occurs at cycle 5 with the first result only.
//  5. DIV start, reset pulsed at cycle 4 -> busy=0, hi=lo=0 immediately.
//     No commit occurs afterwards.
//  6. MTHI rs=0xDEADBEEF -> hi=0xDEADBEEF next cycle, busy never asserted.
//     With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state encoding,
// default latencies and op-class helpers. MDU_MADD_EN enables the SPECIAL2 accumulate ops.
package mdu_pkg;

    typedef logic [3:0] mdu_op_t;

    localparam mdu_op_t MDU_MULT  = 4'd0;
    localparam mdu_op_t MDU_MULTU = 4'd1;
    localparam mdu_op_t MDU_DIV   = 4'd2;
    localparam mdu_op_t MDU_DIVU  = 4'd3;
    localparam mdu_op_t MDU_MTHI  = 4'd4;
    localparam mdu_op_t MDU_MTLO  = 4'd5;
    localparam mdu_op_t MDU_MADD  = 4'd6;
    localparam mdu_op_t MDU_MADDU = 4'd7;
    localparam mdu_op_t MDU_MSUB  = 4'd8;
    localparam mdu_op_t MDU_MSUBU = 4'd9;

    localparam logic [0:0] MDU_IDLE = 1'b0;
    localparam logic [0:0] MDU_BUSY = 1'b1;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

`ifdef MDU_MADD_EN
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } mdu_acc_t;
`endif

    // Ops that take MULT latency; the accumulate ops ride on the multiplier.
    function automatic logic is_mul_op(input mdu_op_t op);
`ifdef MDU_MADD_EN
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_MADD) || (op == MDU_MADDU) ||
               (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
        return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_signed_op(input mdu_op_t op);
`ifdef MDU_MADD_EN
        return (op == MDU_MULT) || (op == MDU_DIV) ||
               (op == MDU_MADD) || (op == MDU_MSUB);
`else
        return (op == MDU_MULT) || (op == MDU_DIV);
`endif
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: 64-bit product or {remainder, quotient} for the given op.
// Division by zero raises div_by_zero; the quotient/remainder are then don't-care.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic        signed_op;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        signed_op = is_signed_op(op);
        a_ext     = signed_op ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
        b_ext     = signed_op ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
        // Low 64 bits of the product are correct for both signednesses once extended.
        prod      = a_ext * b_ext;

        // Magnitudes fit in 32 unsigned bits, including |-2^31|.
        a_neg     = signed_op && rs_val[31];
        b_neg     = signed_op && rt_val[31];
        a_mag     = a_neg ? (32'd0 - rs_val) : rs_val;
        b_mag     = b_neg ? (32'd0 - rt_val) : rt_val;
        div_by_zero = (rt_val == 32'd0);
        b_safe    = div_by_zero ? 32'd1 : b_mag;
        quot_mag  = a_mag / b_safe;
        rem_mag   = a_mag % b_safe;
        quot      = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
        rem       = a_neg ? (32'd0 - rem_mag) : rem_mag;

        result    = is_div_op(op) ? {rem, quot} : prod;
    end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: IDLE/BUSY FSM, latency counter, pending result and HI/LO.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate-at-commit support.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [0:0]    state;
    logic [CW-1:0] count;
    logic [63:0]   pend;
    logic          pending;
    logic [63:0]   arith_result;
    logic          div_by_zero;
    logic [63:0]   commit_val;

    mdu_arith u_arith (
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .result      (arith_result),
        .div_by_zero (div_by_zero)
    );

`ifdef MDU_MADD_EN
    mdu_acc_t pend_acc;

    // Accumulation uses the HI/LO value present at commit, not at start.
    always_comb begin
        unique case (pend_acc)
            ACC_ADD: commit_val = {hi, lo} + pend;
            ACC_SUB: commit_val = {hi, lo} - pend;
            default: commit_val = pend;
        endcase
    end
`else
    assign commit_val = pend;
`endif

    assign busy = (state == MDU_BUSY);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MDU_IDLE;
            count   <= '0;
            pend    <= '0;
            pending <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef MDU_MADD_EN
            pend_acc <= ACC_NONE;
`endif
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (start) begin
                        if (is_mul_op(op)) begin
                            state   <= MDU_BUSY;
                            count   <= CW'(MULT_CYCLES);
                            pend    <= arith_result;
                            pending <= 1'b1;
`ifdef MDU_MADD_EN
                            if (op == MDU_MADD || op == MDU_MADDU)
                                pend_acc <= ACC_ADD;
                            else if (op == MDU_MSUB || op == MDU_MSUBU)
                                pend_acc <= ACC_SUB;
                            else
                                pend_acc <= ACC_NONE;
`endif
                        end else if (is_div_op(op)) begin
                            // A zero divisor still occupies the unit but never commits.
                            state   <= MDU_BUSY;
                            count   <= CW'(DIV_CYCLES);
                            pend    <= arith_result;
                            pending <= !div_by_zero;
`ifdef MDU_MADD_EN
                            pend_acc <= ACC_NONE;
`endif
                        end else if (op == MDU_MTHI) begin
                            hi <= rs_val;
                        end else if (op == MDU_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                MDU_BUSY: begin
                    if (count == CW'(1)) begin
                        state   <= MDU_IDLE;
                        count   <= '0;
                        pending <= 1'b0;
                        if (pending) begin
                            hi <= commit_val[63:32];
                            lo <= commit_val[31:0];
                        end
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, multi-cycle corner
// sequences, and randomized ops against an arithmetic reference model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one op (optionally a second start at busy cycle at_cyc) and counts busy cycles.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int at_cyc, input logic [3:0] io,
                          input logic [31:0] ia, input logic [31:0] ib, output int cyc);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            if (cyc == at_cyc) begin
                start = 1'b1; op = io; rs_val = ia; rt_val = ib;
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Reference: the architectural effect of each op written as plain arithmetic.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l, output int cyc);
        longint          sq, sr;
        logic [63:0]     p;
        longint unsigned ua, ub;
        ua = {32'd0, a};
        ub = {32'd0, b};
        cyc = 0;
        case (o)
            MDU_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {h, l} = p; cyc = MC;
            end
            MDU_MULTU: begin
                p = ua * ub;
                {h, l} = p; cyc = MC;
            end
            MDU_DIV: begin
                cyc = DC;
                if (b != 0) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    l = sq[31:0]; h = sr[31:0];
                end
            end
            MDU_DIVU: begin
                cyc = DC;
                if (b != 0) begin
                    l = a / b; h = a % b;
                end
            end
            MDU_MTHI: h = a;
            MDU_MTLO: l = a;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MSUB: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {h, l} = (o == MDU_MADD) ? ({h, l} + p) : ({h, l} - p);
                cyc = MC;
            end
            MDU_MADDU, MDU_MSUBU: begin
                p = ua * ub;
                {h, l} = (o == MDU_MADDU) ? ({h, l} + p) : ({h, l} - p);
                cyc = MC;
            end
`endif
            default: ;
        endcase
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          cyc;
        logic [31:0] m_hi, m_lo;
        int          m_cyc;
        logic [3:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{MDU_MULT,  32'd3,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[1]  = '{MDU_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        DC};
        vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        vecs[4]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        vecs[5]  = '{MDU_MTHI,  32'h11,       32'd0,        32'h11,       32'h00000001, 0};
        vecs[6]  = '{MDU_MTLO,  32'h22,       32'd0,        32'h11,       32'h22,       0};
        vecs[7]  = '{MDU_DIV,   32'd5,        32'd0,        32'h11,       32'h22,       DC};
        vecs[8]  = '{4'hF,      32'd1,        32'd1,        32'h11,       32'h22,       0};
        vecs[9]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DC};
        vecs[10] = '{MDU_MTHI,  32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'hFFFFFFFD, 0};
        vecs[11] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};

        reset = 1'b1;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, 0, 4'd0, 32'd0, 32'd0, cyc);
            check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // Second start mid-operation is ignored; first result commits on time.
        run_op(MDU_MULT, 32'd3, 32'hFFFFFFFE, 2, MDU_MULTU, 32'd100, 32'd100, cyc);
        check("restart_cycles", cyc, MC);
        check("restart_hi", hi, 32'hFFFFFFFF);
        check("restart_lo", lo, 32'hFFFFFFFA);

        // MTHI during a divide-by-zero busy window must not write HI.
        run_op(MDU_MTHI, 32'h0000ABCD, 32'd0, 0, 4'd0, 32'd0, 32'd0, cyc);
        run_op(MDU_DIV, 32'd9, 32'd0, 4, MDU_MTHI, 32'h12345678, 32'd0, cyc);
        check("mthi_busy_cycles", cyc, DC);
        check("mthi_busy_hi", hi, 32'h0000ABCD);

        // Start on the last busy cycle (count==1) is also ignored.
        run_op(MDU_MULTU, 32'd2, 32'd3, MC, MDU_MTLO, 32'h77777777, 32'd0, cyc);
        check("last_cycle_lo", lo, 32'd6);
        check("last_cycle_idle", {31'd0, busy}, 32'd0);

        // Reset mid-divide discards the pending result.
        run_op(MDU_MTLO, 32'h66, 32'd0, 0, 4'd0, 32'd0, 32'd0, cyc);
        @(negedge clk);
        start = 1'b1; op = MDU_DIV; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_reset_hi", hi, 32'd0);
        check("mid_reset_lo", lo, 32'd0);
        #1 reset = 1'b0;
        repeat (15) @(negedge clk);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        check("post_reset_hi", hi, 32'd0);
        check("post_reset_lo", lo, 32'd0);

`ifdef MDU_MADD_EN
        run_op(MDU_MTHI, 32'd0, 32'd0, 0, 4'd0, 32'd0, 32'd0, cyc);
        run_op(MDU_MTLO, 32'hFFFFFFFF, 32'd0, 0, 4'd0, 32'd0, 32'd0, cyc);
        run_op(MDU_MADDU, 32'd1, 32'd1, 0, 4'd0, 32'd0, 32'd0, cyc);
        check("maddu_cycles", cyc, MC);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
        run_op(MDU_MSUB, 32'd1, 32'd1, 0, 4'd0, 32'd0, 32'd0, cyc);
        check("msub_hi", hi, 32'd0);
        check("msub_lo", lo, 32'hFFFFFFFF);
`else
        run_op(MDU_MTHI, 32'h5, 32'd0, 0, 4'd0, 32'd0, 32'd0, cyc);
        run_op(MDU_MADDU, 32'd1, 32'd1, 0, 4'd0, 32'd0, 32'd0, cyc);
        check("maddu_undef_cycles", cyc, 0);
        check("maddu_undef_hi", hi, 32'h5);
        check("maddu_undef_lo", lo, 32'd0);
`endif

        m_hi = hi;
        m_lo = lo;
        check("model_sync_hi", m_hi, hi);
        for (int i = 0; i < 150; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 5));
                default: ;
            endcase
            model(ro, ra, rb, m_hi, m_lo, m_cyc);
            run_op(ro, ra, rb, 0, 4'd0, 32'd0, 32'd0, cyc);
            check($sformatf("rand%0d_op%0d_cycles", i, ro), cyc, m_cyc);
            check($sformatf("rand%0d_op%0d_hi", i, ro), hi, m_hi);
            check($sformatf("rand%0d_op%0d_lo", i, ro), lo, m_lo);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
